memory_rd_ctrl: RTL and testbench

MEMORY_RD_CTRL -- requirements
Module: memory_rd_ctrl

---
 rtl/memory_rd_ctrl_if.sv | 31 +++
 rtl/memory_rd_ctrl.sv | 156 +++++++++++++++
 tb/tb_memory_rd_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/memory_rd_ctrl_if.sv
// Load-side bus of memory_rd_ctrl: CPU request, synchronous RAM return data and load result.
// The master side owns the request and also plays the RAM by driving mem_rdata.
interface memory_rd_ctrl_if #(
   parameter int addr_width = 10,
   parameter int data_width = 32
);
   logic                  rd_en;
   logic                  wr_en;
   logic [addr_width-1:0] addr;
   logic [data_width-1:0] mem_rdata;
   logic [data_width-1:0] rdata;
   logic                  rdata_valid;

   modport master (
      output rd_en,
      output wr_en,
      output addr,
      output mem_rdata,
      input  rdata,
      input  rdata_valid
   );

   modport slave (
      input  rd_en,
      input  wr_en,
      input  addr,
      input  mem_rdata,
      output rdata,
      output rdata_valid
   );
endinterface

// File: rtl/memory_rd_ctrl.sv
// Load path controller: decodes data memory vs. two captured input ports and a status word,
// returning every accepted load exactly one cycle later.
module memory_rd_ctrl #(
   parameter int addr_width = 10,
   parameter int data_width = 32,
   parameter int in_width   = 10
) (
   input  logic                clk,
   input  logic                rst_n,
   memory_rd_ctrl_if.slave     bus,
   input  logic [in_width-1:0] inport0,
   input  logic [in_width-1:0] inport1,
   input  logic                inport0_en,
   input  logic                inport1_en
);

   localparam logic [addr_width-1:0] ADDR_IN0  = '1;
   localparam logic [addr_width-1:0] ADDR_IN1  = ADDR_IN0 - addr_width'(1);
   localparam logic [addr_width-1:0] ADDR_STAT = ADDR_IN0 - addr_width'(2);

   localparam logic [1:0] SRC_MEM  = 2'd0;
   localparam logic [1:0] SRC_IN0  = 2'd1;
   localparam logic [1:0] SRC_IN1  = 2'd2;
   localparam logic [1:0] SRC_STAT = 2'd3;

   logic                  accept;
   logic [1:0]            src_d;
   logic [1:0]            src_q;
   logic [data_width-1:0] snap_d;
   logic [data_width-1:0] snap_q;
   logic                  valid_q;
   logic [data_width-1:0] hold_q;
   logic [data_width-1:0] rdata_mux;
   logic [data_width-1:0] status_ext;

   logic [1:0]            settle_q;
   logic                  settled;

   logic [in_width-1:0]   port_in   [2];
   logic                  port_en   [2];
   logic [1:0]            sync_q    [2];
   logic                  prev_q    [2];
   logic                  armed_q   [2];
   logic                  cap_edge  [2];
   logic                  clr       [2];
   logic [in_width-1:0]   in_q      [2];
   logic                  new_q     [2];
   logic [data_width-1:0] in_ext    [2];

   assign port_in[0] = inport0;
   assign port_in[1] = inport1;
   assign port_en[0] = inport0_en;
   assign port_en[1] = inport1_en;

   assign accept = bus.rd_en & ~bus.wr_en;

   // The synchronizers hold reset zeros for two edges after release, so a strobe
   // only becomes eligible once a genuine low has been seen after that window.
   assign settled = (settle_q == 2'd2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_q <= 2'd0;
      end else if (!settled) begin
         settle_q <= settle_q + 2'd1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         localparam logic [addr_width-1:0] PORT_ADDR = (gi == 0) ? ADDR_IN0 : ADDR_IN1;

         assign cap_edge[gi] = armed_q[gi] & sync_q[gi][1] & ~prev_q[gi];
         assign clr[gi]      = accept && (bus.addr == PORT_ADDR);
         assign in_ext[gi]   = data_width'(in_q[gi]);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync_q[gi]  <= 2'b00;
               prev_q[gi]  <= 1'b0;
               armed_q[gi] <= 1'b0;
               in_q[gi]    <= '0;
               new_q[gi]   <= 1'b0;
            end else begin
               sync_q[gi] <= {sync_q[gi][0], port_en[gi]};
               prev_q[gi] <= sync_q[gi][1];
               if (settled && !sync_q[gi][1]) begin
                  armed_q[gi] <= 1'b1;
               end
               if (cap_edge[gi]) begin
                  in_q[gi] <= port_in[gi];
               end
               // A capture on the same edge as a clearing read keeps the flag set.
               if (cap_edge[gi]) begin
                  new_q[gi] <= 1'b1;
               end else if (clr[gi]) begin
                  new_q[gi] <= 1'b0;
               end
            end
         end
      end
   endgenerate

   assign status_ext = data_width'({new_q[1], new_q[0]});

   always_comb begin
      src_d = SRC_MEM;
      if (bus.addr == ADDR_IN0) begin
         src_d = SRC_IN0;
      end else if (bus.addr == ADDR_IN1) begin
         src_d = SRC_IN1;
      end else if (bus.addr == ADDR_STAT) begin
         src_d = SRC_STAT;
      end
   end

   // I/O values are snapshotted at the request edge, before any capture lands.
   always_comb begin
      snap_d = '0;
      case (src_d)
         SRC_IN0:  snap_d = in_ext[0];
         SRC_IN1:  snap_d = in_ext[1];
         SRC_STAT: snap_d = status_ext;
         default:  snap_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_q   <= SRC_MEM;
         snap_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= accept;
         if (accept) begin
            src_q  <= src_d;
            snap_q <= snap_d;
         end
      end
   end

   assign rdata_mux = (src_q == SRC_MEM) ? bus.mem_rdata : snap_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= '0;
      end else if (valid_q) begin
         hold_q <= rdata_mux;
      end
   end

   assign bus.rdata       = valid_q ? rdata_mux : hold_q;
   assign bus.rdata_valid = valid_q;

endmodule

// File: tb/tb_memory_rd_ctrl.sv
// Directed bench for memory_rd_ctrl: vector table for the bus path plus hand sequences
// for strobe capture, same-edge set/clear and asynchronous reset.
module tb_memory_rd_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] inport0 = '0;
   logic [9:0] inport1 = '0;
   logic       inport0_en = 1'b0;
   logic       inport1_en = 1'b0;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_hold = '0;

   memory_rd_ctrl_if #(.addr_width(10), .data_width(32)) bus ();

   memory_rd_ctrl #(.addr_width(10), .data_width(32), .in_width(10)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus.slave),
      .inport0    (inport0),
      .inport1    (inport1),
      .inport0_en (inport0_en),
      .inport1_en (inport1_en)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic [9:0]  addr;
      logic [31:0] mem;
      logic        exp_v;
      logic [31:0] exp_d;
   } vec_t;

   vec_t tbl [11];

   task automatic check(input string name, input logic v, input logic [31:0] d,
                        input logic exp_v, input logic [31:0] exp_d);
      checks++;
      if (v !== exp_v || d !== exp_d) begin
         failures++;
         $display("FAIL %s: got valid=%0b rdata=0x%08h, expected valid=%0b rdata=0x%08h",
                  name, v, d, exp_v, exp_d);
      end else begin
         $display("ok   %s: valid=%0b rdata=0x%08h", name, v, d);
      end
   endtask

   // Request driven at negedge; RAM data returned just after the edge; outputs sampled 2ns later.
   task automatic do_cycle(input logic rd, input logic wr, input logic [9:0] addr,
                           input logic [31:0] mem, input logic exp_v,
                           input logic [31:0] exp_d, input string name);
      @(negedge clk);
      bus.rd_en = rd;
      bus.wr_en = wr;
      bus.addr  = addr;
      @(posedge clk);
      #1 bus.mem_rdata = mem;
      #1 check(name, bus.rdata_valid, bus.rdata, exp_v, exp_d);
      if (exp_v) exp_hold = exp_d;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         do_cycle(1'b0, 1'b0, 10'h000, 32'h0, 1'b0, exp_hold, "idle");
      end
   endtask

   task automatic pulse(input int port, input logic [9:0] value);
      if (port == 0) begin
         inport0 = value; inport0_en = 1'b1;
      end else begin
         inport1 = value; inport1_en = 1'b1;
      end
      idle(3);
      if (port == 0) inport0_en = 1'b0;
      else           inport1_en = 1'b0;
      idle(3);
   endtask

   initial begin
      bus.rd_en = 1'b0;
      bus.wr_en = 1'b0;
      bus.addr = '0;
      bus.mem_rdata = '0;

      tbl[0]  = '{1'b1, 1'b0, 10'h010, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
      tbl[1]  = '{1'b1, 1'b0, 10'h3FE, 32'h12345678, 1'b1, 32'h000002AA};
      tbl[2]  = '{1'b1, 1'b0, 10'h011, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D};
      tbl[3]  = '{1'b0, 1'b0, 10'h3FF, 32'h11111111, 1'b0, 32'hCAFEF00D};
      tbl[4]  = '{1'b1, 1'b1, 10'h3FF, 32'h00000005, 1'b0, 32'hCAFEF00D};
      tbl[5]  = '{1'b1, 1'b0, 10'h3FD, 32'h99999999, 1'b1, 32'h00000001};
      tbl[6]  = '{1'b1, 1'b0, 10'h3FC, 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5};
      tbl[7]  = '{1'b1, 1'b0, 10'h3FF, 32'h77777777, 1'b1, 32'h000000AB};
      tbl[8]  = '{1'b1, 1'b0, 10'h3FD, 32'h88888888, 1'b1, 32'h00000000};
      tbl[9]  = '{1'b1, 1'b0, 10'h000, 32'h0F0F0F0F, 1'b1, 32'h0F0F0F0F};
      tbl[10] = '{1'b0, 1'b0, 10'h000, 32'h22222222, 1'b0, 32'h0F0F0F0F};

      // Reset state
      repeat (2) @(posedge clk);
      #1 check("reset", bus.rdata_valid, bus.rdata, 1'b0, 32'h0);
      @(negedge clk) rst_n = 1'b1;
      idle(4);

      // Capture on inport0, status then port read, clearing new0
      pulse(0, 10'h155);
      do_cycle(1'b1, 1'b0, 10'h3FD, 32'hFFFFFFFF, 1'b1, 32'h00000001, "status_after_cap0");
      do_cycle(1'b1, 1'b0, 10'h3FF, 32'hFFFFFFFF, 1'b1, 32'h00000155, "read_in0");
      do_cycle(1'b1, 1'b0, 10'h3FD, 32'hFFFFFFFF, 1'b1, 32'h00000000, "status_cleared");

      pulse(1, 10'h2AA);
      pulse(0, 10'h0AB);

      for (int i = 0; i < 11; i++) begin
         do_cycle(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].mem, tbl[i].exp_v,
                  tbl[i].exp_d, $sformatf("vec%0d", i));
      end

      // Capture on inport1 lands on the same edge as a 0x3FE read
      inport1 = 10'h3C3;
      inport1_en = 1'b1;
      idle(2);
      do_cycle(1'b1, 1'b0, 10'h3FE, 32'h0, 1'b1, 32'h000002AA, "same_edge_old_in1");
      do_cycle(1'b1, 1'b0, 10'h3FD, 32'h0, 1'b1, 32'h00000002, "same_edge_new1_kept");
      do_cycle(1'b1, 1'b0, 10'h3FE, 32'h0, 1'b1, 32'h000003C3, "read_new_in1");
      do_cycle(1'b1, 1'b0, 10'h3FD, 32'h0, 1'b1, 32'h00000000, "new1_cleared");
      inport1_en = 1'b0;
      idle(2);

      // Asynchronous reset during an outstanding read with new0 set
      pulse(0, 10'h155);
      do_cycle(1'b1, 1'b0, 10'h3FD, 32'h0, 1'b1, 32'h00000001, "pre_reset_status");
      @(negedge clk);
      bus.rd_en = 1'b1; bus.wr_en = 1'b0; bus.addr = 10'h3FF;
      @(posedge clk);
      #1 check("pre_reset_read", bus.rdata_valid, bus.rdata, 1'b1, 32'h00000155);
      #1;
      rst_n = 1'b0;
      bus.rd_en = 1'b0;
      inport0 = 10'h0F0;
      inport0_en = 1'b1;
      #1 check("async_reset", bus.rdata_valid, bus.rdata, 1'b0, 32'h0);
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      exp_hold = 32'h0;
      do_cycle(1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 32'h0, "no_pulse_after_reset");
      idle(4);
      do_cycle(1'b1, 1'b0, 10'h3FD, 32'h0, 1'b1, 32'h00000000, "status_after_reset");
      do_cycle(1'b1, 1'b0, 10'h3FF, 32'h0, 1'b1, 32'h00000000, "in0_after_reset");

      // Strobe held across release: only a fresh rise captures
      inport0_en = 1'b0;
      idle(3);
      pulse(0, 10'h0F0);
      do_cycle(1'b1, 1'b0, 10'h3FD, 32'h0, 1'b1, 32'h00000001, "status_after_rearm");
      do_cycle(1'b1, 1'b0, 10'h3FF, 32'h0, 1'b1, 32'h000000F0, "in0_after_rearm");
      do_cycle(1'b1, 1'b0, 10'h3FD, 32'h0, 1'b1, 32'h00000000, "status_final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
